iir_mac_sequencer: RTL and testbench



---
 rtl/iir_seq_pkg.sv | 46 ++++
 rtl/iir_mac_unit.sv | 62 ++++++
 rtl/iir_mac_sequencer.sv | 121 ++++++++++++
 tb/tb_iir_mac_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the time-multiplexed IIR MAC sequencer.
// Optional build macro: IIR_SAT_EN (saturating accumulator and feedback).
package iir_seq_pkg;

  localparam int ORDER    = 8;
  localparam int W_IN     = 8;
  localparam int W_COEF   = 8;
  localparam int ACC_W    = 2*W_IN+4;
  localparam int NUM_TAPS = 2*ORDER;
  localparam int TAP_W    = $clog2(NUM_TAPS);

  localparam logic [3:0] CFG_B0 = 4'd0;
  localparam logic [3:0] CFG_A1 = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic logic signed [W_COEF-1:0] default_coef(
    input logic [3:0] idx
  );
    logic signed [W_COEF-1:0] c;
    unique case (idx)
      4'd0:    c = 8'sd4;
      4'd1:    c = 8'sd22;
      4'd2:    c = 8'sd65;
      4'd3:    c = 8'sd110;
      4'd4:    c = 8'sd110;
      4'd5:    c = 8'sd65;
      4'd6:    c = 8'sd22;
      4'd7:    c = 8'sd6;
      4'd8:    c = 8'sd25;
      4'd9:    c = -8'sd70;
      4'd10:   c = 8'sd99;
      4'd11:   c = -8'sd85;
      4'd12:   c = 8'sd47;
      4'd13:   c = -8'sd16;
      4'd14:   c = 8'sd4;
      default: c = 8'sd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared signed multiplier + accumulator; also derives the feedback sample.
// Optional build macro: IIR_SAT_EN (saturating accumulator and feedback).
module iir_mac_unit
  import iir_seq_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [W_IN-1:0]   sample,
  input  logic signed [W_COEF-1:0] coef,
  input  logic signed [ACC_W-1:0]  fb_src,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic signed [W_IN-1:0]   fb
);

  localparam int PW = W_IN + W_COEF;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = sample * coef;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef IIR_SAT_EN
  logic signed [ACC_W:0]    sum;
  logic        [ACC_W-W_IN:0] upper;

  assign sum   = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign upper = fb_src[ACC_W-1:W_IN-1];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
  end

  // out_data keeps full precision; only the stored history is clamped
  always_comb begin
    fb = fb_src[W_IN-1:0];
    if (!(&upper) && (|upper))
      fb = fb_src[ACC_W-1] ? {1'b1, {(W_IN-1){1'b0}}}
                           : {1'b0, {(W_IN-1){1'b1}}};
  end
`else
  logic unused_fb;

  assign acc_next  = acc + prod_ext;
  assign fb        = fb_src[W_IN-1:0];
  assign unused_fb = ^fb_src[ACC_W-1:W_IN];
`endif

  always_ff @(posedge clock) begin
    if (reset || clear)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/iir_mac_sequencer.sv
// 8th-order direct-form IIR: one MAC swept over 16 taps per sample.
// Optional build macro: IIR_SAT_EN (saturating accumulator and feedback).
module iir_mac_sequencer
  import iir_seq_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [W_IN-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic signed [W_COEF-1:0] cfg_data,
  output logic                     cfg_err,
  input  logic                     flush
);

  state_t state, state_nxt;

  logic [TAP_W-1:0]         tap;
  logic signed [W_COEF-1:0] coef [NUM_TAPS];
  // hist[0]=x0, hist[1..7]=x[1..7], hist[8..15]=y[1..8]
  logic signed [W_IN-1:0]   hist [NUM_TAPS];

  logic                     accept;
  logic                     last;
  logic                     handshake;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [W_IN-1:0]   fb;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_ready && in_valid;
  assign last      = (state == MAC) && (tap == TAP_W'(NUM_TAPS-1));
  assign handshake = (state == OUT) && out_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++)
        coef[i] <= default_coef(4'(i));
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !flush && (state != IDLE);
      if (cfg_we && !flush && (state == IDLE))
        coef[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_TAPS; i++)
        hist[i] <= '0;
    end else if (accept) begin
      hist[0] <= in_data;
    end else if (handshake) begin
      for (int i = 1; i < ORDER; i++)
        hist[i] <= hist[i-1];
      hist[ORDER] <= fb;
      for (int i = ORDER+1; i < NUM_TAPS; i++)
        hist[i] <= hist[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      tap       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept)
        tap <= '0;
      else if (state == MAC)
        tap <= tap + 1'b1;
      if (last) begin
        out_data  <= acc_next;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  iir_mac_unit u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .en       (state == MAC),
    .sample   (hist[tap]),
    .coef     (coef[tap]),
    .fb_src   (out_data),
    .acc      (acc),
    .acc_next (acc_next),
    .fb       (fb)
  );

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Self-checking bench: impulse table, handshake corners, random vs model.
// Optional build macro: IIR_SAT_EN (model follows the saturating variant).
module tb_iir_mac_sequencer;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [7:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic signed [7:0]  cfg_data;
  logic               cfg_err;
  logic               flush;

  int checks = 0;
  int errors = 0;

  int DEF [16] = '{4, 22, 65, 110, 110, 65, 22, 6,
                   25, -70, 99, -85, 47, -16, 4, 1};
  int mc [16];
  int mx [8];
  int my [9];

  typedef struct {
    int din;
    int y;
  } vec_t;
  vec_t tbl [4];

  iir_mac_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .flush     (flush)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap20(input longint v);
    longint r;
    r = v & 64'hFFFFF;
    if (r >= 524288) r = r - 1048576;
    return r;
  endfunction

  function automatic longint step(input longint v);
`ifdef IIR_SAT_EN
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
`else
    return wrap20(v);
`endif
  endfunction

  function automatic int fb_of(input longint y);
`ifdef IIR_SAT_EN
    if (y > 127) return 127;
    if (y < -128) return -128;
    return int'(y);
`else
    return int'(((y & 255) ^ 128) - 128);
`endif
  endfunction

  // y[n] = sum b[k]*x[n-k] + sum a[k]*y[n-k], accumulated in tap order
  function automatic longint model_y(input int s);
    longint acc;
    longint v;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) v = s;
      else if (k < 8) v = mx[k];
      else v = my[k-7];
      acc = step(acc + longint'(mc[k]) * v);
    end
    return acc;
  endfunction

  task automatic commit(input int s, input longint y);
    for (int k = 7; k > 1; k--) mx[k] = mx[k-1];
    mx[1] = s;
    for (int k = 8; k > 1; k--) my[k] = my[k-1];
    my[1] = fb_of(y);
  endtask

  task automatic zero_hist();
    for (int k = 0; k < 8; k++) mx[k] = 0;
    for (int k = 0; k < 9; k++) my[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mc[k] = DEF[k];
    zero_hist();
  endtask

  task automatic wait_valid(output int lat, output bit low_ok);
    lat = 1;
    low_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) low_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) low_ok = 1'b0;
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic send(input int s, input int bp, input bit do_cfg,
                      input int ca, input int cd, input bit chk_lat,
                      input string nm);
    longint y;
    longint hold;
    int lat;
    bit low_ok;
    if (do_cfg) begin
      mc[ca] = cd;
      cfg_we = 1'b1;
      cfg_addr = 4'(ca);
      cfg_data = 8'(cd);
    end
    y = model_y(s);
    in_valid = 1'b1;
    in_data = 8'(s);
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b0;
    wait_valid(lat, low_ok);
    check(nm, out_data, y);
    if (chk_lat) begin
      check("latency", lat, 17);
      check("in_ready_low", low_ok, 1);
    end
    hold = out_data;
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_stable", out_data, hold);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    commit(s, y);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
    mc[a] = d;
    check("cfg_idle_err", cfg_err, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    zero_hist();
  endtask

  initial begin
    longint y;
    int lat;
    bit low_ok;
    bit seen;

    tbl[0] = '{1, 4};
    tbl[1] = '{0, 122};
    tbl[2] = '{0, 2835};
`ifdef IIR_SAT_EN
    tbl[3] = '{0, -4859};
`else
    tbl[3] = '{0, -7559};
`endif

    reset = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    flush = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);

    for (int i = 0; i < 4; i++) begin
      y = model_y(tbl[i].din);
      check("impulse_model", y, tbl[i].y);
      send(tbl[i].din, 0, 1'b0, 0, 0, i == 0, "impulse");
    end

    send(-37, 5, 1'b0, 0, 0, 1'b0, "backpressure");
    send(11, 0, 1'b0, 0, 0, 1'b0, "after_bp");

    do_flush();
    cfg_write(0, -3);
    send(2, 0, 1'b0, 0, 0, 1'b0, "cfg_b0");
    check("cfg_b0_model", mc[0] * 2, -6);

    y = model_y(5);
    in_valid = 1'b1;
    in_data = 8'sd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 8'sd50;
    tick();
    cfg_we = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    tick();
    check("cfg_err_clear", cfg_err, 0);
    wait_valid(lat, low_ok);
    check("mac_write_ignored", out_data, y);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    commit(5, y);

    cfg_write(0, 4);
    in_valid = 1'b1;
    in_data = 8'sd9;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    zero_hist();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_out", seen, 0);
    check("flush_idle", in_ready, 1);
    send(1, 0, 1'b0, 0, 0, 1'b0, "post_flush");
    check("post_flush_const", out_data, 4);

    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 8'sd77;
    flush = 1'b1;
    tick();
    cfg_we = 1'b0;
    flush = 1'b0;
    zero_hist();
    check("flush_cfg_err", cfg_err, 0);
    send(1, 0, 1'b0, 0, 0, 1'b0, "flush_cfg_ignored");

    do_flush();
    for (int i = 0; i < 25; i++) begin
      send($urandom_range(0, 255) - 128, $urandom_range(0, 2),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           $urandom_range(0, 255) - 128, 1'b0, "random");
    end

    cfg_write(0, -3);
    in_valid = 1'b1;
    in_data = 8'sd3;
    tick();
    in_valid = 1'b0;
    wait_valid(lat, low_ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("rst_out_valid_drop", out_valid, 0);
    check("rst_out_in_ready", in_ready, 1);
    check("rst_out_data_zero", out_data, 0);
    tick();
    send(1, 0, 1'b0, 0, 0, 1'b0, "coef_restored");
    check("coef_restored_const", out_data, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
